hex_display_sequencer: RTL and testbench

Drives the six seven-segment HEX PIO slaves of the DNN accelerator system from a single hexadecimal value. Accepts a value over a valid/ready handshake, encodes each nibble to an active-low segment pattern with per-digit blanking and optional leading-zero suppression, and issues Avalon-MM master writes only to digits whose pattern changed. Sits between the accelerator result/status logic and the HEX PIO slaves on the system interconnect.

---
 rtl/hex_display_sequencer.sv | 159 +++++++++++++++
 tb/tb_hex_display_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hex_display_sequencer.sv
// Six-digit seven-segment sequencer: encodes a captured hex value and writes
// only the changed digit patterns to the HEX PIO slaves over Avalon-MM.
module hex_display_sequencer #(
   parameter int unsigned NUM_DIGITS = 6,
   parameter logic [31:0] HEX_BASE   = 32'h0000_1000,
   parameter logic [31:0] HEX_STRIDE = 32'h0000_0010
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [4*NUM_DIGITS-1:0] req_value,
   input  logic [NUM_DIGITS-1:0]   req_blank,
   input  logic                    req_lzs,
   input  logic                    req_force,
   output logic [31:0]             avm_address,
   output logic                    avm_write,
   output logic [31:0]             avm_writedata,
   input  logic                    avm_waitrequest,
   output logic                    busy
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [6:0] BLANK = 7'h7F;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      WRITE
   } state_t;

   state_t                  state, state_d;
   logic [IDX_W-1:0]        idx, idx_d;
   logic [4*NUM_DIGITS-1:0] value_q;
   logic [NUM_DIGITS-1:0]   blank_q;
   logic                    lzs_q;
   logic                    force_q;
   logic [6:0]              shadow [NUM_DIGITS];
   logic [6:0]              pat [NUM_DIGITS];
   logic [6:0]              pat_cur;
   logic [6:0]              shadow_cur;
   logic                    shadow_we;
   logic                    zero_run;

   function automatic logic [6:0] encode(input logic [3:0] nib);
      case (nib)
         4'h0: encode = 7'h40;
         4'h1: encode = 7'h79;
         4'h2: encode = 7'h24;
         4'h3: encode = 7'h30;
         4'h4: encode = 7'h19;
         4'h5: encode = 7'h12;
         4'h6: encode = 7'h02;
         4'h7: encode = 7'h78;
         4'h8: encode = 7'h00;
         4'h9: encode = 7'h10;
         4'hA: encode = 7'h08;
         4'hB: encode = 7'h03;
         4'hC: encode = 7'h46;
         4'hD: encode = 7'h21;
         4'hE: encode = 7'h06;
         default: encode = 7'h0E;
      endcase
   endfunction

   // Zero run is tracked on nibbles only, so a blanked digit ends it only if its nibble is nonzero.
   always_comb begin
      // NOTE: zero_run is a blocking scratch variable; each iteration must see the previous update.
      zero_run = 1'b1;
      for (int i = 0; i < int'(NUM_DIGITS); i++) pat[i] = BLANK;
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
         if (value_q[4*i +: 4] != 4'h0) zero_run = 1'b0;
         if (blank_q[i])                        pat[i] = BLANK;
         else if (lzs_q && zero_run && (i != 0)) pat[i] = BLANK;
         else                                    pat[i] = encode(value_q[4*i +: 4]);
      end
   end

   always_comb begin
      pat_cur    = BLANK;
      shadow_cur = BLANK;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (idx == IDX_W'(i)) begin
            pat_cur    = pat[i];
            shadow_cur = shadow[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         idx     <= '0;
         value_q <= '0;
         blank_q <= '0;
         lzs_q   <= 1'b0;
         force_q <= 1'b0;
         // NOTE: shadows are reset on purpose; they must track the PIOs, which also reset to blank.
         for (int i = 0; i < int'(NUM_DIGITS); i++) shadow[i] <= BLANK;
      end else begin
         state <= state_d;
         idx   <= idx_d;
         if (req_valid && req_ready) begin
            value_q <= req_value;
            blank_q <= req_blank;
            lzs_q   <= req_lzs;
            force_q <= req_force;
         end
         if (shadow_we) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
               if (idx == IDX_W'(i)) shadow[i] <= pat_cur;
            end
         end
      end
   end

   always_comb begin
      state_d       = state;
      idx_d         = idx;
      req_ready     = 1'b0;
      busy          = 1'b1;
      avm_write     = 1'b0;
      avm_address   = '0;
      avm_writedata = '0;
      shadow_we     = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               state_d = SCAN;
               idx_d   = '0;
            end
         end
         SCAN: begin
            if (force_q || (pat_cur != shadow_cur)) state_d = WRITE;
            else if (idx == LAST_IDX)                state_d = IDLE;
            else                                     idx_d   = idx + 1'b1;
         end
         WRITE: begin
            avm_write     = 1'b1;
            avm_address   = HEX_BASE + 32'(idx) * HEX_STRIDE;
            avm_writedata = {25'b0, pat_cur};
            if (!avm_waitrequest) begin
               shadow_we = 1'b1;
               if (idx == LAST_IDX) begin
                  state_d = IDLE;
               end else begin
                  state_d = SCAN;
                  idx_d   = idx + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Directed bench for hex_display_sequencer: table of requests with expected
// digit writes and completion latency, plus a mid-write reset sequence.
module tb_hex_display_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [23:0] req_value;
   logic [5:0]  req_blank;
   logic        req_lzs;
   logic        req_force;
   logic [31:0] avm_address;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic        avm_waitrequest;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hex_display_sequencer dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_value       (req_value),
      .req_blank       (req_blank),
      .req_lzs         (req_lzs),
      .req_force       (req_force),
      .avm_address     (avm_address),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_waitrequest (avm_waitrequest),
      .busy            (busy)
   );

   typedef struct {
      logic [23:0]     value;
      logic [5:0]      blank;
      logic            lzs;
      logic            force_w;
      int              stall;  // waitrequest cycles on the first write
      logic [5:0]      wmask;  // digits expected to be written
      logic [5:0][6:0] wdata;  // expected pattern per digit
      int              lat;    // edges from accept until req_ready seen high
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [23:0] v, input logic [5:0] b, input logic l,
                               input logic f, input int s, input logic [5:0] m,
                               input logic [5:0][6:0] d, input int lat);
      vec_t r;
      r.value = v; r.blank = b; r.lzs = l; r.force_w = f;
      r.stall = s; r.wmask = m; r.wdata = d; r.lat = lat;
      return r;
   endfunction

   task automatic run_req(input vec_t v, input string tag);
      logic [31:0] ea[6];
      logic [6:0]  ed[6];
      int n, wi, cycles, stall_left;
      logic prev_acc;
      n = 0;
      for (int d = 0; d < 6; d++) begin
         if (v.wmask[d]) begin
            ea[n] = 32'h1000 + 32'(d) * 32'h10;
            ed[n] = v.wdata[d];
            n++;
         end
      end
      req_value = v.value; req_blank = v.blank; req_lzs = v.lzs; req_force = v.force_w;
      req_valid = 1'b1;
      check({tag, "_ready_before"}, {31'b0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_value = ~v.value;
      req_blank = ~v.blank;
      req_lzs   = ~v.lzs;
      req_force = ~v.force_w;
      check({tag, "_busy"}, {31'b0, busy}, 32'd1);
      cycles = 1; wi = 0; stall_left = v.stall; prev_acc = 1'b0;
      while (!req_ready && cycles < 100) begin
         avm_waitrequest = avm_write && (stall_left > 0);
         if (avm_waitrequest) stall_left--;
         if (avm_write) begin
            if (prev_acc) begin
               n_checks++; n_fail++;
               $display("FAIL %s_back_to_back: write at cycle %0d follows accepted write", tag, cycles);
            end
            if (wi < n) begin
               check({tag, "_addr"}, avm_address, ea[wi]);
               check({tag, "_data"}, avm_writedata, {25'b0, ed[wi]});
            end else begin
               n_checks++; n_fail++;
               $display("FAIL %s_extra_write: got %h<=%h expected no write", tag, avm_address, avm_writedata);
            end
            if (!avm_waitrequest) wi++;
         end
         prev_acc = avm_write && !avm_waitrequest;
         @(posedge clk); #1;
         cycles++;
      end
      avm_waitrequest = 1'b0;
      if (!req_ready) begin
         n_checks++; n_fail++;
         $display("FAIL %s_timeout: req_ready low after %0d cycles expected high", tag, cycles);
      end else begin
         check({tag, "_latency"}, 32'(cycles), 32'(v.lat));
      end
      check({tag, "_nwrites"}, 32'(wi), 32'(n));
   endtask

   initial begin
      bit found;
      vecs[0] = mk(24'h000123, 6'b000000, 1'b0, 1'b0, 0, 6'b111111,
                   {7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30}, 13);
      vecs[1] = mk(24'h000123, 6'b000000, 1'b0, 1'b0, 0, 6'b000000, '0, 7);
      vecs[2] = mk(24'h000123, 6'b000000, 1'b1, 1'b0, 0, 6'b111000,
                   {7'h7F, 7'h7F, 7'h7F, 7'h00, 7'h00, 7'h00}, 10);
      vecs[3] = mk(24'h000124, 6'b000000, 1'b1, 1'b0, 3, 6'b000001,
                   {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h19}, 11);
      vecs[4] = mk(24'h000124, 6'b000000, 1'b1, 1'b0, 0, 6'b000000, '0, 7);
      vecs[5] = mk(24'h000124, 6'b000000, 1'b1, 1'b1, 0, 6'b111111,
                   {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h19}, 13);
      vecs[6] = mk(24'hABCDEF, 6'b100000, 1'b0, 1'b1, 0, 6'b111111,
                   {7'h7F, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}, 13);
      vecs[7] = mk(24'h000050, 6'b000010, 1'b1, 1'b0, 0, 6'b011111,
                   {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 12);
      vecs[8] = mk(24'h000000, 6'b001000, 1'b1, 1'b0, 0, 6'b000000, '0, 7);

      reset = 1'b1; req_valid = 1'b0; req_value = '0; req_blank = '0;
      req_lzs = 1'b0; req_force = 1'b0; avm_waitrequest = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_ready", {31'b0, req_ready}, 32'd1);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_write", {31'b0, avm_write}, 32'd0);
      check("rst_addr", avm_address, 32'd0);
      check("rst_data", avm_writedata, 32'd0);

      for (int k = 0; k < 9; k++) begin
         run_req(vecs[k], $sformatf("vec%0d", k));
      end

      // Reset while the second write of a full update is stalled.
      req_value = 24'h000123; req_blank = '0; req_lzs = 1'b0; req_force = 1'b0;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         if (avm_write && avm_address == 32'h1010) begin
            found = 1'b1;
            avm_waitrequest = 1'b1;
            reset = 1'b1;
         end else begin
            @(posedge clk); #1;
         end
      end
      check("midrst_found_2nd_write", {31'b0, found}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      avm_waitrequest = 1'b0;
      check("midrst_write", {31'b0, avm_write}, 32'd0);
      check("midrst_ready", {31'b0, req_ready}, 32'd1);
      check("midrst_busy", {31'b0, busy}, 32'd0);
      check("midrst_addr", avm_address, 32'd0);
      run_req(mk(24'h000000, 6'b000000, 1'b1, 1'b0, 0, 6'b000001,
                 {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h40}, 8), "postrst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
